mca_evt_reader: RTL and testbench
=================================

MCA_EVT_READER -- requirements
Module: mca_evt_reader

Interface
REQ-001 SHALL have parameter NBIN_W, default 12, meaning log2 of the histogram bin count (4096 bins).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each bin counter and each event counter.
REQ-003 SHALL have port clk  input  1  single clock for all logic, 125MHz domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low; 0 means reset.
REQ-005 SHALL have port fifo_empty  input  1  event FIFO empty flag.
REQ-006 SHALL have port fifo_rd  output  1  event FIFO pop strobe, one entry per high cycle.
REQ-007 SHALL have port fifo_dout  input  32  event word: [31:14] timing (unsigned), [13:0] peak (signed); valid 1 cycle after fifo_rd.
REQ-008 SHALL have port enable  input  1  H: acquisition allowed; L: no pops.
REQ-009 SHALL have port clr  input  1  H pulse: clear histogram and counters.
REQ-010 SHALL have port thr  input  14  signed lower-level discriminator.
REQ-011 SHALL have port cpu_addr  input  NBIN_W  histogram readout address.
REQ-012 SHALL have port cpu_data  output  CNT_W  bin contents, valid 1 cycle after cpu_addr.
REQ-013 SHALL have port busy  output  1  H during drain/clear.
REQ-014 SHALL have ports evt_cnt and rej_cnt  output  CNT_W each  accepted and rejected event counts.
REQ-015 SHALL have port last_time  output  18  timing field of the last accepted event.

Function
REQ-016 SHALL implement states RUN, DRAIN, CLEAR; RUN -> DRAIN on clr; DRAIN -> CLEAR when pipeline empty (at most 2 cycles); CLEAR -> RUN after last bin written.
REQ-017 SHALL assert fifo_rd only in RUN with enable=1 and fifo_empty=0; sustained throughput one event per cycle.
REQ-018 SHALL use a 3-stage pipeline: S0 pop; S1 word valid, classify, issue RAM read of bin; S2 RAM data, increment, write.
REQ-019 SHALL reject an event (rej_cnt+1, no bin update) when peak <= thr or peak < 0.
REQ-020 SHALL map an accepted event to bin = peak[12:1]; evt_cnt+1 and last_time <= timing in S2.
REQ-021 SHALL, when the S1 bin equals the bin written in the same cycle by S2, use the forwarded write value instead of the RAM read data; back-to-back identical bins SHALL each count.
REQ-022 SHALL saturate bin counters, evt_cnt and rej_cnt at all-ones; no wrap.
REQ-023 SHALL, in CLEAR, write 0 to bins 0..2^NBIN_W-1, one per cycle, and zero evt_cnt, rej_cnt and last_time on entry to CLEAR.
REQ-024 SHALL keep busy=1 in DRAIN and CLEAR, and 0 in RUN.
REQ-025 SHALL ignore clr while busy=1.
REQ-026 SHALL let clr win over a simultaneous pop opportunity; no fifo_rd in the cycle clr is sampled.
REQ-027 SHALL let enable falling stop new pops only; in-flight events complete.
REQ-028 SHALL serve cpu_data from an independent read port at any time; during CLEAR the value is unspecified.

Reset
REQ-029 SHALL, on rst=0, set fifo_rd=0, evt_cnt=0, rej_cnt=0, last_time=0, busy=1, and empty the pipeline.
REQ-030 SHALL enter CLEAR on reset release, since RAM contents are not reset.
REQ-031 SHALL abort any operation on reset mid-clear or mid-run and restart the clear from bin 0 after release.

Structure
REQ-032 SHALL take the event word field positions, PEAK_W=14, TIME_W=18, NBIN_W and CNT_W defaults, and the state encoding from shared package mca_pkg.
REQ-033 SHALL instantiate one sub-module, mca_hist_ram: simple dual-port RAM with write plus 1-cycle read on port A and 1-cycle read on port B, no reset.

Verification
REQ-034 Bench SHALL check: reset release -> busy=1 for 4096+ cycles, then all cpu_data=0, evt_cnt=0.
REQ-035 Bench SHALL check: thr=100, events peak 300, 300, 300 back-to-back -> bin 150 = 3, evt_cnt=3, last_time = third timing.
REQ-036 Bench SHALL check: peaks 100, -5, 101 with thr=100 -> rej_cnt=2, evt_cnt=1, bin 50 = 1.
REQ-037 Bench SHALL check: clr asserted during a FIFO burst -> no pops while busy, counters=0, popping resumes after CLEAR, and no entry is lost or counted twice.
REQ-038 Bench SHALL check: bin preloaded to FFFF_FFFE, then 3 hits -> reads FFFF_FFFF.
REQ-039 Bench SHALL check: enable=0 with fifo_empty=0 -> fifo_rd stays 0.

Source files
------------

// File: rtl/mca_pkg.sv
// mca_pkg: shared definitions for the MCA event reader (event word layout,
// default sizes, controller state encoding and the discriminator rule).
package mca_pkg;

  localparam int EVT_W      = 32;
  localparam int PEAK_W     = 14;
  localparam int TIME_W     = 18;
  localparam int PEAK_LSB   = 0;
  localparam int TIME_LSB   = 14;
  localparam int NBIN_W_DEF = 12;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } mca_state_e;

  // An event is kept only when its peak is non-negative and strictly above threshold.
  function automatic logic evt_accept(input logic signed [PEAK_W-1:0] peak,
                                      input logic signed [PEAK_W-1:0] thr);
    return (peak > thr) && !peak[PEAK_W-1];
  endfunction

endpackage

// File: rtl/mca_hist_ram.sv
// mca_hist_ram: histogram storage. Port A writes and reads (read-before-write,
// one cycle latency); port B is an independent one-cycle read port.
// Contents are deliberately not reset; the controller clears them.
module mca_hist_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];

  // Port A write.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_q[a_waddr] <= a_wdata;
    end
  end

  // Registered reads on both ports; port A returns the pre-write value.
  always_ff @(posedge clk) begin
    a_rdata <= mem_q[a_raddr];
    b_rdata <= mem_q[b_addr];
  end

endmodule

// File: rtl/mca_evt_reader.sv
// mca_evt_reader: pops MCA events from a FIFO, discriminates on peak height and
// accumulates a saturating peak histogram through a 3-stage pipeline
// (S0 pop, S1 classify + bin read, S2 increment + write).
module mca_evt_reader
  import mca_pkg::*;
#(
  parameter int NBIN_W = NBIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic [EVT_W-1:0]         fifo_dout,
  input  logic                     enable,
  input  logic                     clr,
  input  logic signed [PEAK_W-1:0] thr,
  input  logic [NBIN_W-1:0]        cpu_addr,
  output logic [CNT_W-1:0]         cpu_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         evt_cnt,
  output logic [CNT_W-1:0]         rej_cnt,
  output logic [TIME_W-1:0]        last_time
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NBIN_W-1:0] ADDR_ONE = {{(NBIN_W-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  mca_state_e               state_q;
  logic                     busy_q;
  logic [NBIN_W-1:0]        clr_addr_q;
  logic                     v1_q, v2_q, acc2_q, fwd2_q;
  logic [NBIN_W-1:0]        bin2_q;
  logic [TIME_W-1:0]        time2_q, last_time_q;
  logic [CNT_W-1:0]         fwd_data2_q, evt_cnt_q, rej_cnt_q;

  logic signed [PEAK_W-1:0] peak1_s;
  logic [TIME_W-1:0]        time1_s;
  logic [NBIN_W-1:0]        bin1_s;
  logic                     acc1_s, fwd1_s, bin_we_s, drained_s, fifo_rd_s;
  logic [CNT_W-1:0]         ram_a_rdata_s, base2_s, inc2_s;
  logic                     ram_we_s;
  logic [NBIN_W-1:0]        ram_waddr_s;
  logic [CNT_W-1:0]         ram_wdata_s;

  // S1 classify and S2 increment; forward S2's write when S1 targets the same bin.
  always_comb begin
    peak1_s   = fifo_dout[PEAK_LSB +: PEAK_W];
    time1_s   = fifo_dout[TIME_LSB +: TIME_W];
    acc1_s    = evt_accept(peak1_s, thr);
    bin1_s    = peak1_s[NBIN_W:1];
    bin_we_s  = v2_q & acc2_q;
    fwd1_s    = bin_we_s && (bin2_q == bin1_s);
    drained_s = !v1_q && !v2_q;
    if (fwd2_q) begin
      base2_s = fwd_data2_q;
    end else begin
      base2_s = ram_a_rdata_s;
    end
    inc2_s = sat_inc(base2_s);
  end

  // Pop strobe must follow fifo_empty in the same cycle to sustain one pop per cycle.
  always_comb begin
    if ((state_q == ST_RUN) && enable && !fifo_empty && !clr) begin
      fifo_rd_s = 1'b1;
    end else begin
      fifo_rd_s = 1'b0;
    end
  end

  // RAM write port: clearing sweep in CLEAR, otherwise the S2 histogram update.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_q;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = bin_we_s;
      ram_waddr_s = bin2_q;
      ram_wdata_s = inc2_s;
    end
  end

  // Controller: RUN -> DRAIN on clr, DRAIN -> CLEAR once the pipeline is empty,
  // CLEAR sweeps every bin then returns to RUN. Reset starts a fresh sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (clr) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          busy_q <= 1'b1;
          if (drained_s) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (&clr_addr_q) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_ONE;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          busy_q     <= 1'b1;
          clr_addr_q <= '0;
        end
      endcase
    end
  end

  // Pipeline stage registers S0->S1->S2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc2_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      bin2_q      <= '0;
      time2_q     <= '0;
      fwd_data2_q <= '0;
    end else begin
      v1_q        <= fifo_rd_s;
      v2_q        <= v1_q;
      acc2_q      <= acc1_s;
      fwd2_q      <= v1_q & acc1_s & fwd1_s;
      bin2_q      <= bin1_s;
      time2_q     <= time1_s;
      fwd_data2_q <= inc2_s;
    end
  end

  // Event counters and last accepted timing; zeroed on the way into CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_cnt_q   <= '0;
      rej_cnt_q   <= '0;
      last_time_q <= '0;
    end else if ((state_q == ST_DRAIN) && drained_s) begin
      evt_cnt_q   <= '0;
      rej_cnt_q   <= '0;
      last_time_q <= '0;
    end else if (v2_q) begin
      if (acc2_q) begin
        evt_cnt_q   <= sat_inc(evt_cnt_q);
        last_time_q <= time2_q;
      end else begin
        rej_cnt_q   <= sat_inc(rej_cnt_q);
      end
    end
  end

  mca_hist_ram #(
    .AW (NBIN_W),
    .DW (CNT_W)
  ) u_ram (
    .clk     (clk),
    .a_we    (ram_we_s),
    .a_waddr (ram_waddr_s),
    .a_wdata (ram_wdata_s),
    .a_raddr (bin1_s),
    .a_rdata (ram_a_rdata_s),
    .b_addr  (cpu_addr),
    .b_rdata (cpu_data)
  );

  assign fifo_rd   = fifo_rd_s;
  assign busy      = busy_q;
  assign evt_cnt   = evt_cnt_q;
  assign rej_cnt   = rej_cnt_q;
  assign last_time = last_time_q;

endmodule

// File: tb/tb_mca_evt_reader.sv
// tb_mca_evt_reader: self-checking bench. A queue models the event FIFO and a
// histogram/counter model follows the discriminator and binning rules.
// A second instance with 4-bit counters shares the stimulus so saturation can
// be reached with real events.
module tb_mca_evt_reader;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               fifo_empty = 1'b1;
  logic               fifo_rd, fifo_rd2;
  logic [31:0]        fifo_dout = 32'd0;
  logic               enable = 1'b0;
  logic               clr = 1'b0;
  logic signed [13:0] thr = 14'sd100;
  logic [11:0]        cpu_addr = 12'd0;
  logic [31:0]        cpu_data, evt_cnt, rej_cnt;
  logic [17:0]        last_time, last_time2;
  logic               busy, busy2;
  logic [3:0]         cpu_data2, evt_cnt2, rej_cnt2;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] popped_q[$];
  int pop_count = 0, busy_pop_cnt = 0, dis_pop_cnt = 0, clr_pop_cnt = 0, underflow_cnt = 0;

  int          m_hist[int];
  int          m_evt = 0, m_rej = 0;
  logic [17:0] m_time = 18'd0;

  always #4 clk = ~clk;

  mca_evt_reader dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .enable(enable), .clr(clr), .thr(thr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .busy(busy), .evt_cnt(evt_cnt), .rej_cnt(rej_cnt), .last_time(last_time)
  );

  mca_evt_reader #(.NBIN_W(12), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd2), .fifo_dout(fifo_dout),
    .enable(enable), .clr(clr), .thr(thr), .cpu_addr(cpu_addr), .cpu_data(cpu_data2),
    .busy(busy2), .evt_cnt(evt_cnt2), .rej_cnt(rej_cnt2), .last_time(last_time2)
  );

  // FIFO model: data appears one cycle after the pop; empty flag reflects the queue after the pop.
  always @(posedge clk) begin
    logic [31:0] w;
    if (fifo_rd) begin
      if (clr) clr_pop_cnt++;
      if (!enable) dis_pop_cnt++;
      if (busy) busy_pop_cnt++;
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_dout <= w;
        popped_q.push_back(w);
        pop_count++;
      end else begin
        underflow_cnt++;
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_word(input logic [17:0] t, input int pk);
    logic [31:0] p32;
    p32 = pk;
    return {t, p32[13:0]};
  endfunction

  // Reference rule: reject if peak <= thr or negative, otherwise bin = peak / 2.
  function automatic void model_evt(input logic [31:0] w);
    logic signed [13:0] p14;
    int pk, t, b;
    p14 = w[13:0];
    pk  = p14;
    t   = thr;
    if (pk <= t || pk < 0) begin
      m_rej++;
    end else begin
      b = pk / 2;
      if (m_hist.exists(b)) m_hist[b] = m_hist[b] + 1;
      else m_hist[b] = 1;
      m_evt++;
      m_time = w[31:14];
    end
  endfunction

  task automatic wait_busy(input logic val, input int limit, output bit ok, output int n);
    n = 0;
    while (busy !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === val);
  endtask

  task automatic read_bin(input int a, output logic [31:0] d, output logic [3:0] d2);
    @(negedge clk);
    cpu_addr = a[11:0];
    @(negedge clk);
    d  = cpu_data;
    d2 = cpu_data2;
  endtask

  task automatic do_clear();
    bit ok;
    int n;
    wait_busy(1'b0, 6000, ok, n);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL clr_busy: busy=%b want 1", busy); else n_pass++;
    wait_busy(1'b0, 6000, ok, n);
    n_total++;
    if (!ok) $display("FAIL clr_done: busy=%b after %0d cycles want 0", busy, n); else n_pass++;
    m_hist.delete();
    m_evt = 0;
    m_rej = 0;
    m_time = 18'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fifo_q.size() != 0 || !fifo_empty) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_total++;
    if (fifo_q.size() != 0) $display("FAIL idle: fifo still holds %0d entries want 0", fifo_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    bit ok;
    int n, nz;
    logic [31:0] d;
    logic [3:0] d2;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || fifo_rd !== 1'b0) $display("FAIL rst_outputs: busy=%b fifo_rd=%b want 1/0", busy, fifo_rd);
    else n_pass++;
    n_total++;
    if (evt_cnt !== 32'd0 || rej_cnt !== 32'd0 || last_time !== 18'd0)
      $display("FAIL rst_counters: evt=%0d rej=%0d time=%0d want 0", evt_cnt, rej_cnt, last_time);
    else n_pass++;
    rst = 1'b1;
    wait_busy(1'b0, 6000, ok, n);
    n_total++;
    if (!(n >= 4096 && n <= 4100)) $display("FAIL rst_clear_len: busy for %0d cycles want 4096..4100", n);
    else n_pass++;
    nz = 0;
    for (int a = 0; a < 4096; a++) begin
      read_bin(a, d, d2);
      if (d !== 32'd0) nz++;
    end
    n_total++;
    if (nz != 0) $display("FAIL rst_bins_zero: %0d nonzero bins want 0", nz); else n_pass++;
    n_total++;
    if (evt_cnt !== 32'd0) $display("FAIL rst_evt_cnt: got %0d want 0", evt_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, d;
    logic [3:0] d2;
    thr = 14'sd100;
    do_clear();
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      w = mk_word(18'(i * 1111), 300);
      fifo_q.push_back(w);
      model_evt(w);
    end
    wait_idle();
    read_bin(150, d, d2);
    n_total++;
    if (d !== 32'd3 || m_hist[150] != 3) $display("FAIL b2b_bin150: got %0d want 3 (model %0d)", d, m_hist[150]);
    else n_pass++;
    n_total++;
    if (evt_cnt !== 32'd3) $display("FAIL b2b_evt_cnt: got %0d want 3", evt_cnt); else n_pass++;
    n_total++;
    if (last_time !== 18'd3333) $display("FAIL b2b_last_time: got %0d want 3333", last_time); else n_pass++;
  endtask

  task automatic test_reject();
    logic [31:0] d;
    logic [3:0] d2;
    int peaks[3] = '{100, -5, 101};
    thr = 14'sd100;
    do_clear();
    enable = 1'b1;
    @(negedge clk);
    foreach (peaks[i]) fifo_q.push_back(mk_word(18'(500 + i), peaks[i]));
    wait_idle();
    n_total++;
    if (rej_cnt !== 32'd2) $display("FAIL rej_rej_cnt: got %0d want 2", rej_cnt); else n_pass++;
    n_total++;
    if (evt_cnt !== 32'd1) $display("FAIL rej_evt_cnt: got %0d want 1", evt_cnt); else n_pass++;
    read_bin(50, d, d2);
    n_total++;
    if (d !== 32'd1) $display("FAIL rej_bin50: got %0d want 1", d); else n_pass++;
    n_total++;
    if (last_time !== 18'd502) $display("FAIL rej_last_time: got %0d want 502", last_time); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [3:0] d2;
    thr = 14'sd100;
    do_clear();
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) fifo_q.push_back(mk_word(18'(i), 300));
    wait_idle();
    read_bin(150, d, d2);
    n_total++;
    if (d2 !== 4'hE) $display("FAIL sat_preload: narrow bin got %0h want e", d2); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk_word(18'(i), 300));
    wait_idle();
    read_bin(150, d, d2);
    n_total++;
    if (d2 !== 4'hF) $display("FAIL sat_bin: narrow bin got %0h want f", d2); else n_pass++;
    n_total++;
    if (evt_cnt2 !== 4'hF) $display("FAIL sat_evt_cnt: narrow evt_cnt got %0h want f", evt_cnt2); else n_pass++;
    n_total++;
    if (d !== 32'd17) $display("FAIL sat_wide_bin: got %0d want 17", d); else n_pass++;
  endtask

  task automatic test_enable();
    int rd_seen = 0;
    int pc;
    thr = 14'sd0;
    do_clear();
    enable = 1'b0;
    pc = pop_count;
    @(negedge clk);
    for (int i = 0; i < 5; i++) fifo_q.push_back(mk_word(18'(i), 40 + i));
    repeat (30) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) rd_seen++;
    end
    n_total++;
    if (rd_seen != 0 || pop_count != pc) $display("FAIL en_no_pop: fifo_rd high %0d cycles, pops %0d want 0", rd_seen, pop_count - pc);
    else n_pass++;
    enable = 1'b1;
    wait_idle();
    n_total++;
    if (evt_cnt !== 32'd5) $display("FAIL en_resume: evt_cnt got %0d want 5", evt_cnt); else n_pass++;
  endtask

  task automatic test_clr_burst();
    int pops_at;
    logic [31:0] d;
    logic [3:0] d2;
    bit ok;
    int n, bad;
    thr = 14'sd50;
    do_clear();
    enable = 1'b1;
    popped_q.delete();
    pop_count = 0;
    busy_pop_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) fifo_q.push_back(mk_word(18'($urandom), int'($urandom_range(0, 1000))));
    repeat (8) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    pops_at = pop_count;
    n_total++;
    if (!(pops_at > 0 && pops_at < 40)) $display("FAIL burst_midway: %0d pops before clr want 1..39", pops_at);
    else n_pass++;
    repeat (50) @(negedge clk);
    n_total++;
    if (evt_cnt !== 32'd0 || rej_cnt !== 32'd0 || last_time !== 18'd0)
      $display("FAIL burst_cnt_zero: evt=%0d rej=%0d time=%0d want 0", evt_cnt, rej_cnt, last_time);
    else n_pass++;
    wait_busy(1'b0, 6000, ok, n);
    n_total++;
    if (!ok) $display("FAIL burst_clear_done: busy=%b want 0", busy); else n_pass++;
    wait_idle();
    n_total++;
    if (busy_pop_cnt != 0) $display("FAIL burst_busy_pop: %0d pops while busy want 0", busy_pop_cnt); else n_pass++;
    n_total++;
    if (pop_count != 40) $display("FAIL burst_total_pops: got %0d want 40", pop_count); else n_pass++;
    m_hist.delete();
    m_evt = 0;
    m_rej = 0;
    m_time = 18'd0;
    for (int i = pops_at; i < popped_q.size(); i++) model_evt(popped_q[i]);
    n_total++;
    if (evt_cnt !== 32'(m_evt) || rej_cnt !== 32'(m_rej))
      $display("FAIL burst_counts: evt=%0d rej=%0d want %0d/%0d", evt_cnt, rej_cnt, m_evt, m_rej);
    else n_pass++;
    n_total++;
    if (last_time !== m_time) $display("FAIL burst_last_time: got %0d want %0d", last_time, m_time); else n_pass++;
    bad = 0;
    foreach (m_hist[b]) begin
      read_bin(b, d, d2);
      if (d !== 32'(m_hist[b])) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL burst_bins: %0d bins differ from model want 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int t, k, pk, ub;
    logic [31:0] w, d;
    logic [3:0] d2;
    t = int'($urandom_range(0, 600)) - 300;
    thr = 14'(t);
    do_clear();
    for (int it = 0; it < 250; it++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 4) != 0);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) pk = int'($urandom_range(0, 16383)) - 8192;
        else pk = 280 + int'($urandom_range(0, 5));
        w = mk_word(18'($urandom), pk);
        fifo_q.push_back(w);
        model_evt(w);
      end
    end
    enable = 1'b1;
    wait_idle();
    n_total++;
    if (evt_cnt !== 32'(m_evt)) $display("FAIL rnd_evt_cnt: got %0d want %0d", evt_cnt, m_evt); else n_pass++;
    n_total++;
    if (rej_cnt !== 32'(m_rej)) $display("FAIL rnd_rej_cnt: got %0d want %0d", rej_cnt, m_rej); else n_pass++;
    n_total++;
    if (last_time !== m_time) $display("FAIL rnd_last_time: got %0d want %0d", last_time, m_time); else n_pass++;
    foreach (m_hist[b]) begin
      read_bin(b, d, d2);
      n_total++;
      if (d !== 32'(m_hist[b])) $display("FAIL rnd_bin: bin %0d got %0d want %0d", b, d, m_hist[b]);
      else n_pass++;
    end
    ub = 4095;
    while (m_hist.exists(ub)) ub--;
    read_bin(ub, d, d2);
    n_total++;
    if (d !== 32'd0) $display("FAIL rnd_untouched: bin %0d got %0d want 0", ub, d); else n_pass++;
    n_total++;
    if (dis_pop_cnt != 0 || clr_pop_cnt != 0 || underflow_cnt != 0)
      $display("FAIL rd_rules: pops disabled=%0d during_clr=%0d underflow=%0d want 0", dis_pop_cnt, clr_pop_cnt, underflow_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midclear();
    bit ok;
    int n;
    thr = 14'sd0;
    do_clear();
    enable = 1'b1;
    @(negedge clk);
    fifo_q.push_back(mk_word(18'd77, 600));
    wait_idle();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || fifo_rd !== 1'b0 || evt_cnt !== 32'd0)
      $display("FAIL midrst_outputs: busy=%b fifo_rd=%b evt=%0d want 1/0/0", busy, fifo_rd, evt_cnt);
    else n_pass++;
    rst = 1'b1;
    wait_busy(1'b0, 6000, ok, n);
    n_total++;
    if (!(n >= 4096 && n <= 4100)) $display("FAIL midrst_restart: busy for %0d cycles want 4096..4100", n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reject();
    test_saturation();
    test_enable();
    test_clr_burst();
    test_random();
    test_reset_midclear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
